// File: rtl/rvfi_eot_monitor.sv
// End-of-test / health monitor for a multi-port RVFI commit stream (tohost, timeout, no-commit hang).
// Latency: a condition sampled at edge N updates state/end_of_test_o/done_o at that edge, visible in cycle N+1.
// Backpressure: none; a passive observer that never stalls the commit stream.
// Optional feature: define RVFI_EOT_TRAP_COUNT_EN to add trap_count_o and the MaxTraps failure limit.
// NrCommitPorts/PLEN/XLEN mirror the corresponding CVA6 configuration fields.

package rvfi_eot_pkg;
  localparam int unsigned NrCommitPortsDef = 2;
  localparam int unsigned PlenDef          = 56;
  localparam int unsigned XlenDef          = 64;

  typedef struct packed {
    logic                   valid;
    logic                   trap;
    logic [PlenDef-1:0]     mem_paddr;
    logic [XlenDef/8-1:0]   mem_wmask;
    logic [XlenDef-1:0]     mem_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_eot_monitor #(
  parameter int unsigned     NrCommitPorts  = rvfi_eot_pkg::NrCommitPortsDef,
  parameter int unsigned     PLEN           = rvfi_eot_pkg::PlenDef,
  parameter int unsigned     XLEN           = rvfi_eot_pkg::XlenDef,
  parameter type             rvfi_instr_t   = rvfi_eot_pkg::rvfi_instr_t,
  parameter int unsigned     CntWidth       = 64,
  parameter longint unsigned TimeoutCycles  = 200000000,
  parameter int unsigned     WatchdogCycles = 100000
`ifdef RVFI_EOT_TRAP_COUNT_EN
  ,
  parameter int unsigned     MaxTraps       = 0
`endif
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic [PLEN-1:0]                     tohost_addr_i,
  input  rvfi_instr_t [NrCommitPorts-1:0]     rvfi_i,
  output logic [31:0]                         end_of_test_o,
  output logic                                done_o,
  output logic [2:0]                          state_o,
  output logic [CntWidth-1:0]                 cycles_o,
  output logic [CntWidth-1:0]                 instret_o
`ifdef RVFI_EOT_TRAP_COUNT_EN
  ,
  output logic [31:0]                         trap_count_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_e;

  localparam logic [31:0] EotTimeout = 32'hffff_ffff;
  localparam logic [31:0] EotHang    = 32'hffff_fffd;

  state_e                                r_state;
  state_e                                w_state_nxt;
  logic [31:0]                           r_eot;
  logic [31:0]                           w_eot_nxt;
  logic                                  r_done;
  logic [CntWidth-1:0]                   r_cycles;
  logic [CntWidth-1:0]                   r_instret;
  logic [31:0]                           r_wdog;

  logic [NrCommitPorts-1:0][PLEN-1:0]    w_paddr;
  logic [NrCommitPorts-1:0][XLEN-1:0]    w_wdata;
  logic [NrCommitPorts-1:0]              w_valid;
  logic [CntWidth-1:0]                   w_commits;
  logic                                  w_any_commit;
  logic                                  w_hit;
  logic [31:0]                           w_payload;
  logic [CntWidth-1:0]                   w_cycles_nxt;
  logic [31:0]                           w_wdog_nxt;
  logic                                  w_timeout;
  logic                                  w_hang;
  logic                                  w_run_active;
  logic                                  w_enter_term;
  logic                                  w_unused;

`ifdef RVFI_EOT_TRAP_COUNT_EN
  logic [31:0]                           r_trap_cnt;
  logic [31:0]                           w_trap_cnt_nxt;
  logic                                  w_trap_lim;
`endif

  // Only the low payload word and select fields are consumed; keep the rest visibly sunk.
  assign w_unused = ^{rvfi_i, w_wdata};

  // Normalise per-port fields to the configured address/data widths.
  always_comb begin
    w_paddr = '0;
    w_wdata = '0;
    w_valid = '0;
    for (int i = 0; i < int'(NrCommitPorts); i++) begin
      w_paddr[i] = PLEN'(rvfi_i[i].mem_paddr);
      w_wdata[i] = XLEN'(rvfi_i[i].mem_wdata);
      w_valid[i] = rvfi_i[i].valid;
    end
  end

  // Count retired instructions this cycle (trap-only entries have valid=0 and do not count).
  always_comb begin
    w_commits = '0;
    for (int i = 0; i < int'(NrCommitPorts); i++) begin
      w_commits = w_commits + CntWidth'(w_valid[i]);
    end
    w_any_commit = |w_valid;
  end

  // Tohost detection; scanning downward lets the lowest-index hit overwrite the others.
  always_comb begin
    w_hit     = 1'b0;
    w_payload = '0;
    for (int i = int'(NrCommitPorts) - 1; i >= 0; i--) begin
      if (w_valid[i] && (rvfi_i[i].mem_wmask != '0) && (w_paddr[i] == tohost_addr_i) &&
          (tohost_addr_i != '0) && w_wdata[i][0]) begin
        w_hit     = 1'b1;
        w_payload = w_wdata[i][31:0];
      end
    end
  end

  // Next counter values plus timeout/hang conditions evaluated on pre-increment state.
  always_comb begin
    w_cycles_nxt = (&r_cycles) ? r_cycles : r_cycles + CntWidth'(1);
    if (w_any_commit) begin
      w_wdog_nxt = '0;
    end else begin
      w_wdog_nxt = (&r_wdog) ? r_wdog : r_wdog + 32'd1;
    end
    w_timeout = (TimeoutCycles != 0) && (r_cycles >= CntWidth'(TimeoutCycles - 1));
    w_hang    = (WatchdogCycles != 0) && (w_wdog_nxt == WatchdogCycles);
  end

`ifdef RVFI_EOT_TRAP_COUNT_EN
  // Saturating trap total including this cycle's traps, and the limit check against it.
  always_comb begin
    logic [32:0] v_sum;
    v_sum = {1'b0, r_trap_cnt};
    for (int i = 0; i < int'(NrCommitPorts); i++) begin
      v_sum = v_sum + 33'(rvfi_i[i].trap);
    end
    w_trap_cnt_nxt = v_sum[32] ? 32'hffff_ffff : v_sum[31:0];
    w_trap_lim     = (MaxTraps != 0) && (w_trap_cnt_nxt >= MaxTraps);
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and result-code selection; tohost beats timeout beats hang.
  always_comb begin
    w_state_nxt = r_state;
    w_eot_nxt   = r_eot;
    case (r_state)
      S_IDLE: begin
        if (enable_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (enable_i) begin
          if (w_hit) begin
            if (w_payload == 32'd1) begin
              w_state_nxt = S_PASS;
              w_eot_nxt   = 32'd1;
            end else begin
              w_state_nxt = S_FAIL;
              w_eot_nxt   = w_payload;
            end
          end else if (w_timeout) begin
            w_state_nxt = S_TIMEOUT;
            w_eot_nxt   = EotTimeout;
          end else if (w_hang) begin
            w_state_nxt = S_HANG;
            w_eot_nxt   = EotHang;
          end
`ifdef RVFI_EOT_TRAP_COUNT_EN
          else if (w_trap_lim) begin
            w_state_nxt = S_FAIL;
            w_eot_nxt   = 32'hffff_fffb;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // Output decode: counting window and terminal-entry detection.
  always_comb begin
    w_run_active = (r_state == S_RUN) && enable_i;
    w_enter_term = w_run_active && (w_state_nxt != S_RUN);
  end

  // Counters, sticky result word and the one-cycle done strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_eot     <= '0;
      r_done    <= 1'b0;
      r_cycles  <= '0;
      r_instret <= '0;
      r_wdog    <= '0;
    end else begin
      r_done <= w_enter_term;
      r_eot  <= w_eot_nxt;
      if (w_run_active) begin
        r_cycles  <= w_cycles_nxt;
        r_instret <= r_instret + w_commits;
        r_wdog    <= w_wdog_nxt;
      end
    end
  end

`ifdef RVFI_EOT_TRAP_COUNT_EN
  // Trap counter advances only while running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trap_cnt <= '0;
    end else if (w_run_active) begin
      r_trap_cnt <= w_trap_cnt_nxt;
    end
  end

  assign trap_count_o = r_trap_cnt;
`endif

  assign state_o       = r_state;
  assign end_of_test_o = r_eot;
  assign done_o        = r_done;
  assign cycles_o      = r_cycles;
  assign instret_o     = r_instret;

endmodule

// File: tb/tb_rvfi_eot_monitor.sv
// Bench for rvfi_eot_monitor: reference model of the end-of-test rules plus directed scenarios.
// Model and DUT are compared every cycle; scenarios also pin hand-computed literal values.
// Inputs change 1ns after the rising edge; checks run 1-2ns after the edge.

module tb_rvfi_eot_monitor;

  localparam int              NR = 2;
  localparam longint unsigned TO = 50;
  localparam int              WD = 8;
  localparam logic [55:0]     TOHOST = 56'h8000_1000;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PASS = 2, ST_FAIL = 3, ST_TIMEOUT = 4, ST_HANG = 5;

  logic                               clk = 1'b0;
  logic                               rst_n = 1'b0;
  logic                               enable = 1'b0;
  logic [55:0]                        tohost_addr = '0;
  rvfi_eot_pkg::rvfi_instr_t [NR-1:0] rvfi = '0;
  logic [31:0]                        eot;
  logic                               done;
  logic [2:0]                         state;
  logic [63:0]                        cycles;
  logic [63:0]                        instret;
`ifdef RVFI_EOT_TRAP_COUNT_EN
  logic [31:0]                        trap_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rvfi_eot_monitor #(
    .NrCommitPorts (NR),
    .TimeoutCycles (TO),
    .WatchdogCycles(WD)
  ) dut (
`ifdef RVFI_EOT_TRAP_COUNT_EN
    .trap_count_o (trap_count),
`endif
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .tohost_addr_i(tohost_addr),
    .rvfi_i       (rvfi),
    .end_of_test_o(eot),
    .done_o       (done),
    .state_o      (state),
    .cycles_o     (cycles),
    .instret_o    (instret)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_state;
  logic [31:0]     m_eot;
  bit              m_done;
  longint unsigned m_cycles;
  longint unsigned m_instret;
  int              m_quiet;

  always @(posedge clk or negedge rst_n) begin : model
    longint unsigned run_cycle;
    int              retired;
    int              winner;
    logic [31:0]     p;
    if (!rst_n) begin
      m_state = ST_IDLE; m_eot = 0; m_done = 0;
      m_cycles = 0; m_instret = 0; m_quiet = 0;
    end else begin
      m_done = 0;
      if (enable && m_state == ST_IDLE) begin
        m_state = ST_RUN;
      end else if (enable && m_state == ST_RUN) begin
        run_cycle = m_cycles + 1;       // ordinal of this RUN cycle
        retired = 0;
        winner = -1;
        for (int i = 0; i < NR; i++) begin
          if (rvfi[i].valid) retired++;
          if (winner < 0 && rvfi[i].valid && rvfi[i].mem_wmask != 0 &&
              rvfi[i].mem_paddr == tohost_addr && tohost_addr != 0 && rvfi[i].mem_wdata[0])
            winner = i;
        end
        if (m_cycles != 64'hffff_ffff_ffff_ffff) m_cycles = run_cycle;
        m_instret = m_instret + longint'(retired);
        m_quiet = (retired > 0) ? 0 : m_quiet + 1;
        if (winner >= 0) begin
          p = rvfi[winner].mem_wdata[31:0];
          m_state = (p == 1) ? ST_PASS : ST_FAIL;
          m_eot = p;
          m_done = 1;
        end else if (TO != 0 && run_cycle >= TO) begin
          m_state = ST_TIMEOUT; m_eot = 32'hffff_ffff; m_done = 1;
        end else if (WD != 0 && m_quiet >= WD) begin
          m_state = ST_HANG; m_eot = 32'hffff_fffd; m_done = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    check("cmp_state", 64'(state), 64'(m_state));
    check("cmp_eot", 64'(eot), 64'(m_eot));
    check("cmp_done", 64'(done), 64'(m_done));
    check("cmp_cycles", cycles, m_cycles);
    check("cmp_instret", instret, m_instret);
  end

  // ---------------- stimulus helpers ----------------
  function automatic rvfi_eot_pkg::rvfi_instr_t plain();
    rvfi_eot_pkg::rvfi_instr_t r;
    r = '0;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic rvfi_eot_pkg::rvfi_instr_t store(input logic [55:0] a, input logic [63:0] d);
    rvfi_eot_pkg::rvfi_instr_t r;
    r = '0;
    r.valid = 1'b1;
    r.mem_paddr = a;
    r.mem_wmask = 8'hff;
    r.mem_wdata = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    rvfi = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tohost_addr = TOHOST;
    do_reset();
    check("reset_state", 64'(state), 0);
    check("reset_eot", 64'(eot), 0);
    check("reset_cycles", cycles, 0);

    // PASS via port 1 on the 10th enabled cycle; later store of 3 is ignored.
    enable = 1'b1;
    rvfi[0] = plain(); rvfi[1] = plain();
    tick();
    check("t1_run", 64'(state), ST_RUN);
    check("t1_cyc0", cycles, 0);
    repeat (8) tick();
    rvfi[1] = store(TOHOST, 64'd1);
    tick();
    check("t1_state", 64'(state), ST_PASS);
    check("t1_eot", 64'(eot), 1);
    check("t1_done", 64'(done), 1);
    check("t1_cycles", cycles, 9);
    check("t1_instret", instret, 18);
    rvfi[0] = store(TOHOST, 64'd3); rvfi[1] = plain();
    tick();
    check("t1_done_low", 64'(done), 0);
    check("t1_eot_sticky", 64'(eot), 1);
    check("t1_cyc_frozen", cycles, 9);

    // Asynchronous reset while in PASS.
    #3;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("t6_state", 64'(state), 0);
    check("t6_eot", 64'(eot), 0);
    check("t6_done", 64'(done), 0);
    check("t6_cycles", cycles, 0);
    check("t6_instret", instret, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_done", 64'(done), 0);
    check("t6_idle", 64'(state), 0);

    // Simultaneous hits: port 0 (payload 7) wins over port 1 (payload 1).
    do_reset();
    enable = 1'b1;
    rvfi[0] = plain(); rvfi[1] = plain();
    tick();
    tick();
    rvfi[0] = store(TOHOST, 64'd7); rvfi[1] = store(TOHOST, 64'd1);
    tick();
    check("t2_state", 64'(state), ST_FAIL);
    check("t2_eot", 64'(eot), 7);
    check("t2_done", 64'(done), 1);
    check("t2_cycles", cycles, 2);
    check("t2_instret", instret, 4);

    // Timeout after exactly 50 RUN cycles with commits every cycle.
    do_reset();
    enable = 1'b1;
    rvfi[0] = plain(); rvfi[1] = plain();
    tick();
    repeat (49) tick();
    check("t3_still_run", 64'(state), ST_RUN);
    check("t3_cyc49", cycles, 49);
    tick();
    check("t3_state", 64'(state), ST_TIMEOUT);
    check("t3_eot", 64'(eot), 64'h0000_0000_ffff_ffff);
    check("t3_cycles", cycles, 50);
    check("t3_instret", instret, 100);
    check("t3_done", 64'(done), 1);
    tick();
    check("t3_frozen", cycles, 50);

    // Hang: commits stop after 5 cycles; a commit on idle cycle 7 restarts the watchdog.
    do_reset();
    enable = 1'b1;
    rvfi[0] = plain(); rvfi[1] = plain();
    tick();
    repeat (5) tick();
    rvfi[0] = store(TOHOST, 64'd1);
    rvfi[0].valid = 1'b0;
    rvfi[0].trap = 1'b1;
    rvfi[1] = '0;
    repeat (6) tick();
    check("t4_trap_only", 64'(state), ST_RUN);
    rvfi[0] = plain(); rvfi[1] = plain();
    tick();
    rvfi = '0;
    repeat (7) tick();
    check("t4_wd7_run", 64'(state), ST_RUN);
    tick();
    check("t4_state", 64'(state), ST_HANG);
    check("t4_eot", 64'(eot), 64'h0000_0000_ffff_fffd);
    check("t4_cycles", cycles, 20);
    check("t4_instret", instret, 12);
    check("t4_done", 64'(done), 1);

    // Enable gap and disabled tohost (address 0).
    do_reset();
    tohost_addr = '0;
    enable = 1'b1;
    rvfi[0] = store(56'h0, 64'd1); rvfi[1] = plain();
    tick();
    repeat (10) tick();
    enable = 1'b0;
    repeat (5) tick();
    check("t5_hold_cyc", cycles, 10);
    check("t5_hold_state", 64'(state), ST_RUN);
    enable = 1'b1;
    repeat (10) tick();
    check("t5_cycles", cycles, 20);
    check("t5_instret", instret, 40);
    check("t5_state", 64'(state), ST_RUN);
    check("t5_eot", 64'(eot), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
